// File: rtl/sha_multi_round_stage.sv
// One pipeline stage of a SHA-256 compression core: ROUNDS chained rounds starting at
// round K_BASE, a matching advance of the 16-word schedule window, and one output register.
module sha_multi_round_stage #(
  parameter int K_BASE = 0,
  parameter int ROUNDS = 1,
  parameter int EXPAND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0][31:0]  state_i,
  input  logic [15:0][31:0] W_i,
  input  logic              valid_i,
  input  logic              newblock_i,
  output logic              ready_o,
  output logic [7:0][31:0]  state_o,
  output logic [15:0][31:0] W_o,
  output logic              valid_o,
  output logic              newblock_o,
  input  logic              ready_i
);

  if (ROUNDS != 1 && ROUNDS != 2 && ROUNDS != 4) begin : g_bad_rounds
    $error("sha_multi_round_stage: ROUNDS must be 1, 2 or 4");
  end
  if (K_BASE < 0 || K_BASE + ROUNDS > 64) begin : g_bad_base
    $error("sha_multi_round_stage: K_BASE+ROUNDS must not exceed 64");
  end

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [7:0][31:0]  state_next;
  logic [15:0][31:0] w_next;
  logic [31:0]       t1;
  logic [31:0]       t2;
  logic [31:0]       new_word;

  // State word 0 is a and word 7 is h; every sub-round consumes w[0] then advances the window.
  always_comb begin
    state_next = state_i;
    w_next     = W_i;
    t1         = '0;
    t2         = '0;
    new_word   = '0;
    for (int r = 0; r < ROUNDS; r++) begin
      t1 = state_next[7] + big_sigma1(state_next[4])
         + ((state_next[4] & state_next[5]) ^ (~state_next[4] & state_next[6]))
         + K_TABLE[6'(K_BASE + r)] + w_next[0];
      t2 = big_sigma0(state_next[0])
         + ((state_next[0] & state_next[1]) ^ (state_next[0] & state_next[2]) ^ (state_next[1] & state_next[2]));
      state_next = {state_next[6], state_next[5], state_next[4], state_next[3] + t1,
                    state_next[2], state_next[1], state_next[0], t1 + t2};
      new_word = (EXPAND != 0)
               ? small_sigma1(w_next[14]) + w_next[9] + small_sigma0(w_next[1]) + w_next[0]
               : w_next[0];
      w_next = {new_word, w_next[15:1]};
    end
  end

  assign ready_o = !valid_o || ready_i;

  // Control advances on every ready edge; data only moves when a real beat is captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o    <= 1'b0;
      newblock_o <= 1'b0;
      state_o    <= '0;
      W_o        <= '0;
    end else if (ready_o) begin
      valid_o    <= valid_i;
      newblock_o <= newblock_i & valid_i;
      if (valid_i) begin
        state_o <= state_next;
        W_o     <= w_next;
      end
    end
  end

endmodule

// File: tb/tb_sha_multi_round_stage.sv
// Self-checking bench for sha_multi_round_stage: known-answer rounds, rotate mode, stalls,
// reset mid-stream, and a full 64-round chain hashing "abc" under random back-pressure.
module tb_sha_multi_round_stage;

  typedef logic [7:0][31:0]  st8_t;
  typedef logic [15:0][31:0] w16_t;

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam st8_t H0 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                         32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam st8_t DIGEST = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                             32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam w16_t W_ABC = {32'h00000018, 448'h0, 32'h61626380};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  st8_t state_in;
  w16_t w_in;
  logic valid_in, nb_in, ready_in;

  logic dut_ready, dut_valid, dut_nb;
  st8_t dut_state;
  w16_t dut_w;
  logic d2_ready, d2_valid, d2_nb;
  st8_t d2_state;
  w16_t d2_w;
  logic d4_ready, d4_valid, d4_nb;
  st8_t d4_state;
  w16_t d4_w;

  st8_t ch_state;
  w16_t ch_w;
  logic ch_valid, ch_nb, ch_ready, sink_ready;

  int checks = 0;
  int failures = 0;

  st8_t sb_state[$];
  w16_t sb_w[$];
  logic sb_nb[$];

  sha_multi_round_stage #(.K_BASE(0), .ROUNDS(1), .EXPAND(1)) dut (
    .clk(clk), .rst(rst), .state_i(state_in), .W_i(w_in), .valid_i(valid_in),
    .newblock_i(nb_in), .ready_o(dut_ready), .state_o(dut_state), .W_o(dut_w),
    .valid_o(dut_valid), .newblock_o(dut_nb), .ready_i(ready_in));

  sha_multi_round_stage #(.K_BASE(0), .ROUNDS(2), .EXPAND(1)) dut2 (
    .clk(clk), .rst(rst), .state_i(state_in), .W_i(w_in), .valid_i(valid_in),
    .newblock_i(nb_in), .ready_o(d2_ready), .state_o(d2_state), .W_o(d2_w),
    .valid_o(d2_valid), .newblock_o(d2_nb), .ready_i(ready_in));

  sha_multi_round_stage #(.K_BASE(60), .ROUNDS(4), .EXPAND(0)) dut4 (
    .clk(clk), .rst(rst), .state_i(state_in), .W_i(w_in), .valid_i(valid_in),
    .newblock_i(nb_in), .ready_o(d4_ready), .state_o(d4_state), .W_o(d4_w),
    .valid_o(d4_valid), .newblock_o(d4_nb), .ready_i(ready_in));

  // Sixteen 4-round stages make one full 64-round compression pipeline.
  for (genvar i = 0; i < 16; i++) begin : g_chain
    st8_t st_in, st_out;
    w16_t w_in_c, w_out;
    logic vld_in, vld_out, nbi, nbo, rdy_in, rdy_out;
    sha_multi_round_stage #(.K_BASE(4 * i), .ROUNDS(4), .EXPAND(1)) u_stage (
      .clk(clk), .rst(rst), .state_i(st_in), .W_i(w_in_c), .valid_i(vld_in),
      .newblock_i(nbi), .ready_o(rdy_out), .state_o(st_out), .W_o(w_out),
      .valid_o(vld_out), .newblock_o(nbo), .ready_i(rdy_in));
    if (i == 0) begin : g_head
      assign st_in  = ch_state;
      assign w_in_c = ch_w;
      assign vld_in = ch_valid;
      assign nbi    = ch_nb;
    end else begin : g_link
      assign st_in  = g_chain[i-1].st_out;
      assign w_in_c = g_chain[i-1].w_out;
      assign vld_in = g_chain[i-1].vld_out;
      assign nbi    = g_chain[i-1].nbo;
    end
    if (i == 15) begin : g_tail
      assign rdy_in = sink_ready;
    end else begin : g_fwd
      assign rdy_in = g_chain[i+1].rdy_out;
    end
  end
  assign ch_ready = g_chain[0].rdy_out;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference model: expands the whole schedule as a flat array rather than shifting a window.
  function automatic void golden(input st8_t si, input w16_t wi, input int kb, input int nr,
                                 input bit ex, output st8_t so, output w16_t wo);
    logic [31:0] s [0:79];
    logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
    for (int j = 0; j < 80; j++) s[j] = (j < 16) ? wi[j] : 32'h0;
    for (int j = 16; j < 16 + nr; j++) begin
      if (ex)
        s[j] = (rr(s[j-2], 17) ^ rr(s[j-2], 19) ^ (s[j-2] >> 10)) + s[j-7]
             + (rr(s[j-15], 7) ^ rr(s[j-15], 18) ^ (s[j-15] >> 3)) + s[j-16];
      else
        s[j] = s[j-16];
    end
    {h, g, f, e, d, c, b, a} = si;
    for (int r = 0; r < nr; r++) begin
      x1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) | (~e & g)) + K_TB[kb + r] + s[r];
      x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) | (a & c) | (b & c));
      h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
    end
    so = {h, g, f, e, d, c, b, a};
    for (int j = 0; j < 16; j++) wo[j] = s[j + nr];
  endfunction

  task automatic randomize_inputs;
    for (int i = 0; i < 8; i++) state_in[i] = $urandom();
    for (int j = 0; j < 16; j++) w_in[j] = $urandom();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    valid_in = 1'b0; nb_in = 1'b0; ready_in = 1'b0;
    state_in = '0; w_in = '0;
    ch_valid = 1'b0; ch_nb = 1'b0; ch_state = '0; ch_w = '0; sink_ready = 1'b0;
    #2;
    checks++;
    if ({dut_valid, dut_nb, d2_valid, d2_nb, d4_valid, d4_nb} !== 6'b0) begin
      failures++; $display("[TB] FAIL reset_ctrl: got %b expected 000000", {dut_valid, dut_nb, d2_valid, d2_nb, d4_valid, d4_nb});
    end
    checks++;
    if (dut_state !== '0 || dut_w !== '0 || d4_state !== '0) begin
      failures++; $display("[TB] FAIL reset_data: got state %h expected 0", dut_state);
    end
    checks++;
    if ({dut_ready, d2_ready, d4_ready, ch_ready} !== 4'b1111) begin
      failures++; $display("[TB] FAIL reset_ready: got %b expected 1111", {dut_ready, d2_ready, d4_ready, ch_ready});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (dut_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL ready_after_reset: got %b expected 1", dut_ready);
    end
  endtask

  task automatic test_abc_rounds;
    @(negedge clk);
    state_in = H0; w_in = W_ABC; valid_in = 1'b1; nb_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    checks++;
    if (dut_valid !== 1'b1 || dut_nb !== 1'b1) begin
      failures++; $display("[TB] FAIL abc_r1_valid: got %b%b expected 11", dut_valid, dut_nb);
    end
    checks++;
    if (dut_state[0] !== 32'h5d6aebcd || dut_state[4] !== 32'hfa2a4622) begin
      failures++; $display("[TB] FAIL abc_r1_ae: got a=%h e=%h expected a=5d6aebcd e=fa2a4622", dut_state[0], dut_state[4]);
    end
    checks++;
    if (dut_w[15] !== 32'h61626380) begin
      failures++; $display("[TB] FAIL abc_r1_w15: got %h expected 61626380", dut_w[15]);
    end
    checks++;
    if (d2_state[0] !== 32'h5a6ad9ad || d2_state[4] !== 32'h78ce7989) begin
      failures++; $display("[TB] FAIL abc_r2_ae: got a=%h e=%h expected a=5a6ad9ad e=78ce7989", d2_state[0], d2_state[4]);
    end
    checks++;
    if (d2_w[14] !== 32'h61626380 || d2_w[15] !== 32'h000f0000) begin
      failures++; $display("[TB] FAIL abc_r2_w: got w14=%h w15=%h expected 61626380 000f0000", d2_w[14], d2_w[15]);
    end
    @(negedge clk);
  endtask

  task automatic test_rotate;
    st8_t es;
    w16_t ew;
    @(negedge clk);
    randomize_inputs();
    for (int j = 0; j < 16; j++) w_in[j] = j;
    valid_in = 1'b1; nb_in = 1'b0; ready_in = 1'b1;
    golden(state_in, w_in, 60, 4, 1'b0, es, ew);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (d4_w[j] !== 32'((j + 4) % 16)) begin
        failures++; $display("[TB] FAIL rotate_w[%0d]: got %h expected %h", j, d4_w[j], 32'((j + 4) % 16));
      end
    end
    checks++;
    if (d4_state !== es || d4_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL rotate_state: got %h expected %h", d4_state, es);
    end
    @(negedge clk);
  endtask

  // Scripted stall window at cycles 3..5 with toggling valid, then random back-to-back traffic.
  task automatic test_stall_back_to_back;
    st8_t es;
    w16_t ew;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ready_in = (c >= 3 && c < 6) ? 1'b0 : ((c < 12) ? 1'b1 : 1'($urandom_range(0, 1)));
      valid_in = (c < 12) ? (c < 3 || (c % 2) == 0) : 1'($urandom_range(0, 3) != 0);
      nb_in = 1'($urandom_range(0, 1));
      randomize_inputs();
      #1;
      if (dut_valid && ready_in) begin
        checks++;
        if (sb_state.size() == 0) begin
          failures++; $display("[TB] FAIL stall_extra_beat: got valid_o=1 expected no beat");
        end else begin
          es = sb_state.pop_front(); ew = sb_w.pop_front();
          if (dut_state !== es || dut_w !== ew || dut_nb !== sb_nb.pop_front()) begin
            failures++; $display("[TB] FAIL stall_beat: got %h expected %h", dut_state, es);
          end
        end
      end else if (dut_valid && !ready_in) begin
        checks++;
        if (dut_ready !== 1'b0 || sb_state.size() == 0 || dut_state !== sb_state[0] || dut_w !== sb_w[0]) begin
          failures++; $display("[TB] FAIL stall_frozen: got ready=%b state=%h expected ready=0 held beat", dut_ready, dut_state);
        end
      end
      if (dut_ready && valid_in) begin
        golden(state_in, w_in, 0, 1, 1'b1, es, ew);
        sb_state.push_back(es); sb_w.push_back(ew); sb_nb.push_back(nb_in);
      end
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (dut_valid) begin
        checks++;
        if (sb_state.size() == 0) begin
          failures++; $display("[TB] FAIL drain_extra_beat: got valid_o=1 expected no beat");
        end else begin
          es = sb_state.pop_front(); ew = sb_w.pop_front();
          if (dut_state !== es || dut_w !== ew || dut_nb !== sb_nb.pop_front()) begin
            failures++; $display("[TB] FAIL drain_beat: got %h expected %h", dut_state, es);
          end
        end
      end
    end
    checks++;
    if (sb_state.size() != 0 || dut_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL drain_empty: got %0d pending valid=%b expected 0 pending valid=0", sb_state.size(), dut_valid);
    end
  endtask

  task automatic test_reset_midstream;
    st8_t es;
    w16_t ew;
    @(negedge clk);
    randomize_inputs();
    valid_in = 1'b1; nb_in = 1'b1; ready_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b0; nb_in = 1'b0;
    #1;
    checks++;
    if (dut_valid !== 1'b1 || dut_nb !== 1'b1) begin
      failures++; $display("[TB] FAIL midrst_pre: got %b%b expected 11", dut_valid, dut_nb);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({dut_valid, dut_nb, d2_valid, d2_nb} !== 4'b0 || dut_state !== '0 || dut_w !== '0 || d2_state !== '0 || d2_w !== '0) begin
      failures++; $display("[TB] FAIL midrst_clear: got valid=%b nb=%b state=%h expected all zero", dut_valid, dut_nb, dut_state);
    end
    checks++;
    if (dut_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL midrst_ready: got %b expected 1", dut_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    randomize_inputs();
    valid_in = 1'b1; nb_in = 1'b0; ready_in = 1'b1;
    golden(state_in, w_in, 0, 1, 1'b1, es, ew);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    checks++;
    if (dut_valid !== 1'b1 || dut_state !== es || dut_w !== ew) begin
      failures++; $display("[TB] FAIL midrst_after: got valid=%b state=%h expected 1 %h", dut_valid, dut_state, es);
    end
    @(negedge clk);
  endtask

  task automatic test_chain_digest;
    st8_t exp_state, fin, q_state[$];
    w16_t exp_w;
    int sent = 0;
    int done = 0;
    golden(H0, W_ABC, 0, 64, 1'b1, exp_state, exp_w);
    for (int c = 0; c < 400 && !(sent == 5 && q_state.size() == 0); c++) begin
      @(negedge clk);
      ch_state = H0; ch_w = W_ABC; ch_nb = 1'b1;
      ch_valid = (sent < 5) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      sink_ready = 1'($urandom_range(0, 1));
      #1;
      if (g_chain[15].vld_out && sink_ready) begin
        checks++;
        if (q_state.size() == 0) begin
          failures++; $display("[TB] FAIL chain_extra_beat: got valid_o=1 expected no beat");
        end else begin
          void'(q_state.pop_front());
          for (int i = 0; i < 8; i++) fin[i] = g_chain[15].st_out[i] + H0[i];
          if (fin !== DIGEST || g_chain[15].st_out !== exp_state || g_chain[15].w_out !== exp_w || g_chain[15].nbo !== 1'b1) begin
            failures++; $display("[TB] FAIL chain_digest: got %h expected %h", fin, DIGEST);
          end
          done++;
        end
      end
      if (ch_ready && ch_valid) begin
        q_state.push_back(exp_state);
        sent++;
      end
    end
    ch_valid = 1'b0;
    checks++;
    if (done != 5) begin
      failures++; $display("[TB] FAIL chain_count: got %0d expected 5", done);
    end
  endtask

  initial begin
    test_reset();
    test_abc_rounds();
    test_rotate();
    test_stall_back_to_back();
    test_reset_midstream();
    test_chain_digest();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
